// File: rtl/mux41_pkg.sv
// Shared types and constants for the mux41 round-robin arbiter and its
// integration with the mux41 datapath.
package mux41_pkg;

    // Arbiter FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Two-bit select, identical to the mux41 {i_SEL1,i_SEL0} encoding
    typedef logic [1:0] sel_t;

    // Requester indices (bit positions in the request vector)
    localparam sel_t IDX_A = 2'd0;
    localparam sel_t IDX_B = 2'd1;
    localparam sel_t IDX_C = 2'd2;
    localparam sel_t IDX_D = 2'd3;

    // One-hot grant pattern for a given owner index
    function automatic logic [3:0] onehot4(input sel_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux41_arb_if.sv
// Request/grant bundle between requesters and the mux41 arbiter.
// The slave side is the arbiter; the master side is whoever drives requests.
interface mux41_arb_if;
    logic [3:0] i_REQ;
    logic [3:0] o_GNT;
    logic       o_SEL0;
    logic       o_SEL1;
    logic       o_VALID;

    modport slave (
        input  i_REQ,
        output o_GNT,
        output o_SEL0,
        output o_SEL1,
        output o_VALID
    );

    modport master (
        output i_REQ,
        input  o_GNT,
        input  o_SEL0,
        input  o_SEL1,
        input  o_VALID
    );
endinterface

// File: rtl/mux41_arb_rr_pick4.sv
// Combinational circular priority picker: returns the first asserted
// request searching from ptr upward (ptr, ptr+1, ptr+2, ptr+3 mod 4).
module rr_pick4
    import mux41_pkg::*;
(
    input  logic [3:0] req_i,
    input  sel_t       ptr_i,
    output sel_t       idx_o,
    output logic       any_o
);

    // Rotate the request vector so that bit 0 is the highest-priority slot
    logic [3:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot[gi] = req_i[sel_t'(ptr_i + sel_t'(gi))];
        end
    endgenerate

    sel_t off;

    // Lowest set bit of the rotated vector gives the offset from ptr
    always_comb begin
        off = '0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) begin
                off = sel_t'(k);
            end
        end
    end

    assign idx_o = sel_t'(ptr_i + off);
    assign any_o = |req_i;

endmodule

// File: rtl/mux41_arb.sv
// Round-robin arbiter owning the mux41 select lines. Grants are held until
// the owner drops its request or HOLD_MAX consecutive cycles elapse; on
// release the pointer moves past the old owner and a new pick happens in
// the same cycle, so back-to-back grants have no idle gap.
module mux41_arb
    import mux41_pkg::*;
#(
    parameter  int HOLD_MAX = 4,
    localparam int CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic          i_CLK,
    input  logic          i_RST_N,
    mux41_arb_if.slave    bus
);

    arb_state_t       state_q;
    sel_t             own_q;
    sel_t             ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       gnt_q;
    logic             valid_q;

    sel_t             pick_ptr_d;
    sel_t             pick_idx;
    logic             pick_any;
    logic             release_d;

    // While busy, a release searches from just past the current owner;
    // from idle the stored pointer is used unchanged.
    always_comb begin
        pick_ptr_d = ptr_q;
        if (state_q == ST_BUSY) begin
            pick_ptr_d = sel_t'(own_q + 2'd1);
        end
    end

    assign release_d = !bus.i_REQ[own_q] ||
                       (cnt_q == CNT_W'(HOLD_MAX - 1));

    rr_pick4 u_pick (
        .req_i (bus.i_REQ),
        .ptr_i (pick_ptr_d),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Arbiter FSM with hold counter, priority pointer and registered outputs
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q <= ST_IDLE;
            own_q   <= IDX_A;
            ptr_q   <= IDX_A;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q <= ST_BUSY;
                        own_q   <= pick_idx;
                        cnt_q   <= '0;
                        gnt_q   <= onehot4(pick_idx);
                        valid_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!release_d) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        ptr_q <= pick_ptr_d;
                        cnt_q <= '0;
                        if (pick_any) begin
                            own_q <= pick_idx;
                            gnt_q <= onehot4(pick_idx);
                        end else begin
                            // Select lines keep their last value while idle
                            state_q <= ST_IDLE;
                            gnt_q   <= 4'b0000;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_GNT   = gnt_q;
    assign bus.o_SEL1  = own_q[1];
    assign bus.o_SEL0  = own_q[0];
    assign bus.o_VALID = valid_q;

endmodule

// File: doc/mux41_arb.md
# mux41_arb

Round-robin arbiter that shares one `mux41` 4:1 datapath between four requesters A–D. It owns the `mux41` select lines and a one-hot grant vector, and holds each grant until the requester releases it or a hold limit expires. It sits directly in front of `mux41`: `o_SEL1`/`o_SEL0` wire straight to `i_SEL1`/`i_SEL0`. All outputs are registered, so the mux select never glitches mid-cycle.

## Interface
- Parameters:
  - HOLD_MAX, default 4: maximum consecutive cycles one owner may hold a grant. Legal range 1..255.
  - CNT_W, default $clog2(HOLD_MAX+1): hold counter width. Derived; never overridden.
- Ports:
  - i_CLK  in  1  sole clock; all state changes on its rising edge.
  - i_RST_N  in  1  reset, synchronous, active-low.
  - i_REQ  in  4  request vector; bit0=A, bit1=B, bit2=C, bit3=D.
  - o_GNT  out  4  one-hot grant; all zeros when idle.
  - o_SEL0  out  1  LSB of owner index; drives mux41 i_SEL0.
  - o_SEL1  out  1  MSB of owner index; drives mux41 i_SEL1.
  - o_VALID  out  1  high while a grant is active, so the mux output is meaningful.

## Operation
- State machine has two states:
  - IDLE: no owner.
  - BUSY: owner index `own` (2 bits), hold counter `cnt`, priority pointer `ptr` (2 bits).
- Pick function: first asserted bit of i_REQ, searching circularly from `ptr` upward (ptr, ptr+1, ..., ptr+3 mod 4).
- IDLE:
  - If i_REQ != 0: next state is BUSY, `own` = pick, `cnt` = 0.
  - Otherwise stay in IDLE.
- BUSY, with release = !i_REQ[own] || (cnt == HOLD_MAX-1):
  - No release: `cnt` increments; owner and select outputs are unchanged.
  - Release: `ptr` becomes own+1 mod 4, and the pick is evaluated with that new pointer in the same cycle.
    - If the pick finds a request: stay in BUSY with the new owner and `cnt` = 0. There is no idle gap.
    - If i_REQ == 0: go to IDLE.
- The expiring owner is still eligible after a hold expiry, but at the lowest priority. It is re-granted, with `cnt` restarted, only if no other requester is asserting.
- `ptr` changes only on release; granting from IDLE leaves it unchanged.
- Outputs:
  - {o_SEL1,o_SEL0} = own.
  - o_GNT = 1<<own in BUSY, 0 in IDLE.
  - o_VALID = (state == BUSY).
- In IDLE, o_SEL holds its last value. Downstream must qualify on o_VALID.
- Requests are level-sensitive; the block has no request latching. A request dropped before it is granted is lost.

## Timing
- Reset (i_RST_N low at an edge) gives: state IDLE, o_GNT=0000, o_SEL1/o_SEL0=00, o_VALID=0, ptr=0, cnt=0.
  - Reset applied mid-grant aborts the grant at that edge.
  - Reset overrides all other inputs.
- Grant latency: a request seen in IDLE at edge N produces o_GNT/o_VALID/o_SEL from edge N onward (visible in cycle N+1). That is one cycle.
- Maximum hold: an owner that keeps requesting is granted for exactly HOLD_MAX consecutive cycles.
  - With HOLD_MAX=1, every cycle is a release, so the arbiter rotates among active requesters every cycle.
- Owner drop: if the owner deasserts in cycle K, its grant ends at the edge closing cycle K. The next owner, if any, appears in cycle K+1.
- Simultaneous events: owner drop together with new requests is an ordinary release plus pick at the same edge.
- Fairness bound: with all four requesters asserting continuously, each waits at most 3*HOLD_MAX cycles between grants.
- o_GNT is always one-hot or zero, and always consistent with o_SEL and o_VALID.

## Structure
- Package mux41_pkg holds:
  - the state enum (ST_IDLE, ST_BUSY);
  - the index constants IDX_A=0, IDX_B=1, IDX_C=2, IDX_D=3;
  - the 2-bit select typedef, shared with mux41 integration.
- Sub-module rr_pick4 (purely combinational):
  - inputs: 4-bit req, 2-bit ptr;
  - outputs: 2-bit idx, 1-bit any.
- The top level holds the FSM, the counter, the pointer and the output registers.

## Test plan
- Reset and single request: hold i_RST_N low for 2 cycles, then release with i_REQ=0001.
  - Expect o_VALID=0, o_GNT=0000, SEL=00 during reset.
  - One cycle after release, expect o_GNT=0001, SEL=00, o_VALID=1.
- Hold expiry, HOLD_MAX=4: i_REQ=0011 constant.
  - Expect A for 4 cycles, then B for 4 cycles, then A again.
  - No idle cycles at the switch.
- Early drop: B is owner and i_REQ changes from 0110 to 0100 after 2 cycles.
  - Next cycle expect C granted (SEL=10) with cnt restarted.
- Full rotation: i_REQ=1111 with HOLD_MAX=1.
  - Expect grant sequence A,B,C,D,A each cycle, i.e. SEL 00,01,10,11,00.
- Sole expired owner: i_REQ=1000 with HOLD_MAX=2.
  - Expect D granted continuously, o_GNT=1000 with no gap.
  - Expect ptr to be 0 after each expiry.
- Mid-grant reset: C owner, i_RST_N low for one edge.
  - Expect outputs cleared the next cycle.
  - After release with i_REQ=1100 and ptr=0, expect C granted first, because the search from ptr 0 hits C before D.
